alu_exec: RTL and testbench

//  Execute-stage ALU that consumes the 4-bit ALUCtrl code produced by ALU control decode.

---
 rtl/alu_pkg.sv | 18 +
 rtl/mul_iter.sv | 81 ++++++++
 rtl/alu_exec.sv | 130 +++++++++++++
 tb/tb_alu_exec.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage FSM encoding; also imported by ALU control decode.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_XOR  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_ADD  = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd4;
    localparam logic [3:0] ALU_MUL  = 4'd5;
    localparam logic [3:0] ALU_ADDI = 4'd6;
    localparam logic [3:0] ALU_SRAI = 4'd7;
    localparam logic [3:0] ALU_LWSW = 4'd8;
    localparam logic [3:0] ALU_BEQ  = 4'd9;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per cycle.
// done_c/prod_c are combinational: they present the final accumulation during the last step.
module mul_iter #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_c,
    output logic [WIDTH-1:0] prod_c
);

    localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] step_sum_c;

    // Sum of this cycle's partial products on top of the running accumulator.
    always_comb begin
        step_sum_c = acc_q;
        for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
            if (b_q[j]) begin
                step_sum_c = step_sum_c + (a_q << j);
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        done_c = 1'b0;
        prod_c = step_sum_c;
        if (abort_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            acc_d  = '0;
            a_d    = a_i;
            b_d    = b_i;
        end else if (busy_q) begin
            acc_d = step_sum_c;
            a_d   = a_q << BITS_PER_CYCLE;
            b_d   = b_q >> BITS_PER_CYCLE;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) begin
                done_c = 1'b1;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops with registered results, mul via mul_iter with pipeline stall.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             stall_o
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    logic [0:0]       state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             ready_q, ready_d;
    logic             stall_q, stall_d;

    logic [SH_W-1:0]  shamt_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             mul_start_c;
    logic             mul_abort_c;
    logic             mul_done_c;
    logic [WIDTH-1:0] mul_prod_c;

    mul_iter #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start_c),
        .abort_i (mul_abort_c),
        .a_i     (data1_i),
        .b_i     (data2_i),
        .done_c  (mul_done_c),
        .prod_c  (mul_prod_c)
    );

    assign shamt_c = data2_i[SH_W-1:0];

    // Single-cycle datapath; mul and undefined codes produce zero here.
    always_comb begin
        alu_res_c = '0;
        case (ALUCtrl_i)
            ALU_AND:                     alu_res_c = data1_i & data2_i;
            ALU_XOR:                     alu_res_c = data1_i ^ data2_i;
            ALU_SLL:                     alu_res_c = data1_i << shamt_c;
            ALU_ADD, ALU_ADDI, ALU_LWSW: alu_res_c = data1_i + data2_i;
            ALU_SUB, ALU_BEQ:            alu_res_c = data1_i - data2_i;
            ALU_SRAI:                    alu_res_c = WIDTH'($signed(data1_i) >>> shamt_c);
            default:                     alu_res_c = '0;
        endcase
    end

    // Flush beats both a new issue in IDLE and a completing mul.
    always_comb begin
        state_d     = state_q;
        valid_d     = 1'b0;
        data_d      = data_q;
        zero_d      = zero_q;
        mul_start_c = 1'b0;
        mul_abort_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i && !flush_i) begin
                    if (ALUCtrl_i == ALU_MUL) begin
                        mul_start_c = 1'b1;
                        state_d     = S_MUL;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = alu_res_c;
                        zero_d  = (alu_res_c == '0);
                    end
                end
            end
            S_MUL: begin
                if (flush_i) begin
                    mul_abort_c = 1'b1;
                    state_d     = S_IDLE;
                end else if (mul_done_c) begin
                    state_d = S_IDLE;
                    valid_d = 1'b1;
                    data_d  = mul_prod_c;
                    zero_d  = (mul_prod_c == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        stall_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            ready_q <= 1'b1;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            ready_q <= ready_d;
            stall_q <= stall_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign zero_o  = zero_q;
    assign ready_o = ready_q;
    assign stall_o = stall_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec (WIDTH=32, BITS_PER_CYCLE=1) with hand-computed expectations.
module tb_alu_exec;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  ALUCtrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic        valid_o;
    logic [31:0] data_o;
    logic        zero_o;
    logic        stall_o;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    alu_exec #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .zero_o    (zero_o),
        .stall_o   (stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
        valid_i   = v;
        flush_i   = f;
        ALUCtrl_i = c;
        data1_i   = a;
        data2_i   = b;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    // Issue one single-cycle op, check the pulse and result, then check the pulse drops.
    task automatic single(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic expz);
        drive(1'b1, 1'b0, c, a, b);
        step();
        chk({tag, "_valid"}, 32'(valid_o), 32'd1);
        chk({tag, "_data"}, data_o, exp);
        chk({tag, "_zero"}, 32'(zero_o), 32'(expz));
        idle();
        step();
        chk({tag, "_pulse"}, 32'(valid_o), 32'd0);
        chk({tag, "_hold"}, data_o, exp);
    endtask

    initial begin
        int seen;
        rst_i = 1'b0;
        idle();
        step();
        step();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data",  data_o,       32'd0);
        chk("rst_zero",  32'(zero_o),  32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_stall", 32'(stall_o), 32'd0);
        rst_i = 1'b1;
        step();

        single("add",     4'd3,  32'd5,         32'd7,         32'd12,        1'b0);
        single("beq",     4'd9,  32'h1234,      32'h1234,      32'd0,         1'b1);
        single("srai",    4'd7,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0);
        single("srai36",  4'd7,  32'h8000_0000, 32'd36,        32'hF800_0000, 1'b0);
        single("sll",     4'd2,  32'd1,         32'd31,        32'h8000_0000, 1'b0);
        single("and",     4'd0,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0);
        single("xor",     4'd1,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0);
        single("sub",     4'd4,  32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0);
        single("addi",    4'd6,  32'd10,        32'hFFFF_FFFF, 32'd9,         1'b0);
        single("lwsw",    4'd8,  32'h1000,      32'h0FFC,      32'h1FFC,      1'b0);
        single("code12",  4'd12, 32'd77,        32'd88,        32'd0,         1'b1);

        // mul 3 * -2 with junk valid_i during the stall window.
        drive(1'b1, 1'b0, 4'd5, 32'd3, 32'hFFFF_FFFE);
        step();
        chk("mul_acc_valid", 32'(valid_o), 32'd0);
        chk("mul_acc_ready", 32'(ready_o), 32'd0);
        drive(1'b1, 1'b0, 4'd3, 32'd100, 32'd200);
        seen = 0;
        for (int i = 1; i <= 31; i++) begin
            step();
            if (valid_o !== 1'b0 || ready_o !== 1'b0 || stall_o !== 1'b1) seen++;
        end
        chk("mul_window", 32'(seen), 32'd0);
        idle();
        step();
        chk("mul_valid", 32'(valid_o), 32'd1);
        chk("mul_data",  data_o,       32'hFFFF_FFFA);
        chk("mul_zero",  32'(zero_o),  32'd0);
        chk("mul_ready", 32'(ready_o), 32'd1);
        chk("mul_stall", 32'(stall_o), 32'd0);
        idle();
        step();
        chk("mul_pulse", 32'(valid_o), 32'd0);

        // 0x10000 squared, then an add issued in the completion cycle.
        drive(1'b1, 1'b0, 4'd5, 32'h1_0000, 32'h1_0000);
        step();
        idle();
        for (int i = 1; i <= 31; i++) step();
        step();
        chk("mul0_valid", 32'(valid_o), 32'd1);
        chk("mul0_data",  data_o,       32'd0);
        chk("mul0_zero",  32'(zero_o),  32'd1);
        drive(1'b1, 1'b0, 4'd3, 32'd5, 32'd7);
        step();
        chk("b2b_valid", 32'(valid_o), 32'd1);
        chk("b2b_data",  data_o,       32'd12);
        chk("b2b_zero",  32'(zero_o),  32'd0);
        idle();
        step();

        // Flush at mul cycle 10.
        drive(1'b1, 1'b0, 4'd5, 32'd3, 32'd5);
        step();
        idle();
        for (int i = 1; i <= 9; i++) step();
        drive(1'b0, 1'b1, 4'd0, 32'd0, 32'd0);
        step();
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_ready", 32'(ready_o), 32'd1);
        chk("flush_stall", 32'(stall_o), 32'd0);
        chk("flush_data",  data_o,       32'd12);
        drive(1'b1, 1'b0, 4'd3, 32'd2, 32'd2);
        step();
        chk("postflush_valid", 32'(valid_o), 32'd1);
        chk("postflush_data",  data_o,       32'd4);
        idle();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (valid_o !== 1'b0) seen++;
        end
        chk("flush_no_late", 32'(seen), 32'd0);

        // Asynchronous reset at mul cycle 5.
        drive(1'b1, 1'b0, 4'd5, 32'd3, 32'd5);
        step();
        idle();
        for (int i = 1; i <= 4; i++) step();
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_data",  data_o,       32'd0);
        chk("arst_zero",  32'(zero_o),  32'd0);
        chk("arst_ready", 32'(ready_o), 32'd1);
        chk("arst_stall", 32'(stall_o), 32'd0);
        step();
        rst_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (valid_o !== 1'b0 || ready_o !== 1'b1) seen++;
        end
        chk("arst_no_late", 32'(seen), 32'd0);

        // flush_i with valid_i in IDLE drops the op.
        drive(1'b1, 1'b1, 4'd3, 32'd9, 32'd9);
        step();
        chk("drop_valid", 32'(valid_o), 32'd0);
        chk("drop_data",  data_o,       32'd0);
        idle();
        step();
        chk("drop_after", 32'(valid_o), 32'd0);
        single("after_drop", 4'd3, 32'd9, 32'd9, 32'd18, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
